// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite constants used by the read initiator and the read slave.
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] AR_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_master_read_if.sv
// AXI4-Lite read address and read data channels between initiator and memory slave.
interface axi4_lite_master_read_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 32
);

   // A transfer happens on a rising edge where VALID and READY are both high;
   // the sender holds VALID and its payload stable until that edge.
   logic              AR_VALID;
   logic [ADDR_W-1:0] AR_ADDR;
   logic [2:0]        AR_PROT;
   logic              AR_READY;
   logic              R_READY;
   logic [DATA_W-1:0] R_DATA;
   logic [1:0]        R_RESP;
   logic              R_VALID;

   modport master (
      output AR_VALID, AR_ADDR, AR_PROT, R_READY,
      input  AR_READY, R_DATA, R_RESP, R_VALID
   );

   modport slave (
      input  AR_VALID, AR_ADDR, AR_PROT, R_READY,
      output AR_READY, R_DATA, R_RESP, R_VALID
   );

endinterface

// File: rtl/axi4_lite_master_read.sv
// Block-fill read initiator: issues BLOCK_WORDS single-beat AXI4-Lite reads from an
// aligned base and streams each returned word with its index.
module axi4_lite_master_read
   import axi4_lite_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int BLOCK_WORDS    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_start_read,
   input  logic [AXI_ADDR_WIDTH-1:0]     i_addr,
   output logic [AXI_DATA_WIDTH-1:0]     o_data,
   output logic                          o_data_valid,
   output logic [$clog2(BLOCK_WORDS)-1:0] o_word_idx,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_error,
   output logic [1:0]                    dbg_state,
   axi4_lite_master_read_if.master       axi
);

   localparam int IDX_W      = $clog2(BLOCK_WORDS);
   localparam int ALIGN_BITS = $clog2(BLOCK_WORDS * AXI_DATA_WIDTH / 8);
   localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
      ~((AXI_ADDR_WIDTH'(1) << ALIGN_BITS) - AXI_ADDR_WIDTH'(1));
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);
   localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } t_state;

   t_state                    state_q;
   t_state                    state_d;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
   logic [IDX_W-1:0]          count_q;
   logic                      err_q;
   logic [AXI_DATA_WIDTH-1:0] data_q;
   logic [IDX_W-1:0]          idx_q;
   logic                      dv_q;
   logic                      ar_hs;
   logic                      r_hs;
   logic                      r_bad;
   logic                      ar_valid;
   logic                      r_ready;

   assign ar_hs = (state_q == ADDR) && axi.AR_READY;
   assign r_hs  = (state_q == DATA) && axi.R_VALID;
   assign r_bad = (axi.R_RESP != RESP_OKAY);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (i_start_read) state_d = ADDR;
         ADDR: if (ar_hs) state_d = DATA;
         DATA: begin
            if (r_hs) begin
               if (r_bad || (count_q == LAST_IDX)) state_d = DONE;
               else                                state_d = ADDR;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control outputs are pure decodes of the state register, so they change only on edges.
   always_comb begin
      ar_valid  = (state_q == ADDR);
      r_ready   = (state_q == DATA);
      o_busy    = (state_q != IDLE);
      o_done    = (state_q == DONE);
      o_error   = (state_q == DONE) && err_q;
      dbg_state = state_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ar_addr_q <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
         data_q    <= '0;
         idx_q     <= '0;
         dv_q      <= 1'b0;
      end else begin
         dv_q <= 1'b0;
         if ((state_q == IDLE) && i_start_read) begin
            ar_addr_q <= i_addr & ALIGN_MASK;
            count_q   <= '0;
            err_q     <= 1'b0;
         end
         if (r_hs) begin
            data_q <= axi.R_DATA;
            idx_q  <= count_q;
            dv_q   <= 1'b1;
            if (r_bad) begin
               err_q <= 1'b1;
            end else if (count_q != LAST_IDX) begin
               // Address tracks base + count*bytes; alignment keeps the sum inside the block.
               count_q   <= count_q + IDX_W'(1);
               ar_addr_q <= ar_addr_q + ADDR_STEP;
            end
         end
      end
   end

   assign o_data       = data_q;
   assign o_word_idx   = idx_q;
   assign o_data_valid = dv_q;

   assign axi.AR_VALID = ar_valid;
   assign axi.AR_ADDR  = ar_addr_q;
   assign axi.AR_PROT  = AR_PROT_DEFAULT;
   assign axi.R_READY  = r_ready;

endmodule

// File: tb/tb_axi4_lite_master_read.sv
// Bench for axi4_lite_master_read: reactive memory slave, fill-level reference model and
// per-cycle compare process, driven by directed scenarios.
module tb_axi4_lite_master_read;

   logic        clk;
   logic        rst;
   logic        i_start_read;
   logic [63:0] i_addr;
   logic [31:0] o_data;
   logic        o_data_valid;
   logic [3:0]  o_word_idx;
   logic        o_busy;
   logic        o_done;
   logic        o_error;
   logic [1:0]  dbg_state;

   axi4_lite_master_read_if #(.ADDR_W(64), .DATA_W(32)) axi_bus ();

   axi4_lite_master_read #(
      .AXI_ADDR_WIDTH(64),
      .AXI_DATA_WIDTH(32),
      .BLOCK_WORDS(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .i_start_read(i_start_read),
      .i_addr(i_addr),
      .o_data(o_data),
      .o_data_valid(o_data_valid),
      .o_word_idx(o_word_idx),
      .o_busy(o_busy),
      .o_done(o_done),
      .o_error(o_error),
      .dbg_state(dbg_state),
      .axi(axi_bus.master)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ 32'hC3A5_5A3C ^ {a[7:0], a[7:0], a[15:8], a[23:16]};
   endfunction

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   cyc = 0;
   logic rst_at_edge = 1'b0;
   always @(posedge clk) begin
      cyc++;
      rst_at_edge = rst;
   end

   // ---------------- memory slave ----------------
   int          ar_delay = 0;
   int          r_delay  = 0;
   int          err_word = -1;
   logic        spurious_r = 1'b0;
   logic        ar_ready, r_valid;
   logic [31:0] r_data;
   logic [1:0]  r_resp;

   assign axi_bus.AR_READY = ar_ready;
   assign axi_bus.R_VALID  = r_valid;
   assign axi_bus.R_DATA   = r_data;
   assign axi_bus.R_RESP   = r_resp;

   initial begin : slave
      int          phase;
      int          ar_wait;
      int          r_wait;
      logic [63:0] pend;
      phase = 0; ar_wait = 0; r_wait = 0; pend = '0;
      ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
      forever begin
         @(posedge clk); #2;
         if (!o_busy) begin phase = 0; ar_wait = 0; r_wait = 0; end
         if (phase == 2) begin phase = 0; ar_wait = 0; end
         if (phase == 0) begin
            r_valid = spurious_r;
            r_data  = 32'hDEAD_BEEF;
            r_resp  = 2'b10;
            if (axi_bus.AR_VALID) begin
               if (ar_wait >= ar_delay) begin
                  ar_ready = 1'b1;
                  pend     = axi_bus.AR_ADDR;
                  phase    = 1;
                  r_wait   = 0;
               end else begin
                  ar_ready = 1'b0;
                  ar_wait++;
               end
            end else begin
               ar_ready = 1'b0;
            end
         end else if (phase == 1) begin
            ar_ready = 1'b0;
            if (r_wait >= r_delay) begin
               r_valid = 1'b1;
               r_data  = mem_word(pend);
               r_resp  = (int'(pend[5:2]) == err_word) ? 2'b10 : 2'b00;
               phase   = 2;
            end else begin
               r_valid = 1'b0;
               r_wait++;
            end
         end
      end
   end

   // ---------------- reference model + scoreboard ----------------
   logic [63:0] exp_addr_q[$];
   logic [31:0] exp_q[$];
   logic [3:0]  exp_idx_q[$];
   logic        exp_err = 1'b0;
   logic        model_busy = 1'b0;
   int          done_cnt = 0, dv_cnt = 0, ar_cnt = 0;
   int          done_cyc = 0, accept_cyc = 0;
   logic        last_done_err = 1'b0;
   logic [3:0]  last_idx = '0, first_idx = '0;
   logic [63:0] first_ar = '0, last_ar = '0;

   task automatic clear_stats();
      dv_cnt = 0; ar_cnt = 0;
   endtask

   initial begin : monitor
      logic        ar_wait_prev;
      logic [63:0] ar_addr_prev;
      logic        fill_end;
      logic [63:0] base;
      int          nwords;
      ar_wait_prev = 1'b0; ar_addr_prev = '0;
      forever begin
         @(negedge clk);
         fill_end = 1'b0;
         if (rst_at_edge) begin
            check("rst_busy", o_busy, 0);
            check("rst_done", o_done, 0);
            check("rst_error", o_error, 0);
            check("rst_dv", o_data_valid, 0);
            check("rst_ar_valid", axi_bus.AR_VALID, 0);
            check("rst_r_ready", axi_bus.R_READY, 0);
            check("rst_ar_addr", axi_bus.AR_ADDR, 0);
            check("rst_ar_prot", axi_bus.AR_PROT, 0);
            check("rst_data", o_data, 0);
            check("rst_idx", o_word_idx, 0);
            exp_addr_q.delete(); exp_q.delete(); exp_idx_q.delete();
            model_busy   = 1'b0;
            ar_wait_prev = 1'b0;
         end else begin
            check("busy", o_busy, model_busy);
            check("ar_prot", axi_bus.AR_PROT, 0);
            check("ar_r_overlap", axi_bus.AR_VALID & axi_bus.R_READY, 0);
            if (ar_wait_prev) begin
               check("ar_hold_valid", axi_bus.AR_VALID, 1);
               check("ar_hold_addr", axi_bus.AR_ADDR, ar_addr_prev);
            end
            if (!model_busy)
               check("idle_quiet", {axi_bus.AR_VALID, axi_bus.R_READY, o_data_valid, o_done}, 0);
            if (axi_bus.AR_VALID && axi_bus.AR_READY) begin
               if (exp_addr_q.size() == 0) begin
                  check("extra_ar", 1, 0);
               end else begin
                  check("ar_addr", axi_bus.AR_ADDR, exp_addr_q.pop_front());
                  if (ar_cnt == 0) first_ar = axi_bus.AR_ADDR;
                  last_ar = axi_bus.AR_ADDR;
                  ar_cnt++;
               end
            end
            if (o_data_valid) begin
               if (exp_q.size() == 0) begin
                  check("extra_beat", 1, 0);
               end else begin
                  check("data", o_data, exp_q.pop_front());
                  check("word_idx", o_word_idx, exp_idx_q.pop_front());
                  if (dv_cnt == 0) first_idx = o_word_idx;
                  last_idx = o_word_idx;
                  dv_cnt++;
                  if (exp_q.size() == 0) begin
                     check("done_at_last", o_done, 1);
                     check("done_error", o_error, exp_err);
                     fill_end = 1'b1;
                  end else begin
                     check("no_early_done", o_done, 0);
                  end
               end
            end else if (o_done) begin
               check("done_without_beat", 1, 0);
            end
            if (o_done) begin
               done_cnt++;
               done_cyc      = cyc;
               last_done_err = o_error;
            end
            ar_wait_prev = axi_bus.AR_VALID && !axi_bus.AR_READY;
            ar_addr_prev = axi_bus.AR_ADDR;
         end
         if (fill_end) begin
            model_busy = 1'b0;
            exp_addr_q.delete();
         end else if (!rst && i_start_read && !model_busy) begin
            base    = i_addr & ~64'h3F;
            nwords  = (err_word >= 0) ? err_word + 1 : 16;
            exp_err = (err_word >= 0);
            for (int k = 0; k < nwords; k++) begin
               exp_addr_q.push_back(base + 64'(4 * k));
               exp_q.push_back(mem_word(base + 64'(4 * k)));
               exp_idx_q.push_back(4'(k));
            end
            model_busy = 1'b1;
            accept_cyc = cyc;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic start_fill(input logic [63:0] a);
      i_start_read = 1'b1;
      i_addr       = a;
      step();
      i_start_read = 1'b0;
   endtask

   task automatic wait_done(input int target, input string name);
      int n;
      n = 0;
      while (done_cnt < target && n < 600) begin
         step();
         n++;
      end
      check({name, "_done_timeout"}, (done_cnt >= target), 1);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin : main
      int n;
      int d1;
      rst = 1'b1; i_start_read = 1'b0; i_addr = '0;
      repeat (3) step();
      rst = 1'b0;
      step();
      check("reset_state", dbg_state, 0);

      // Clean fill, slave always ready
      clear_stats();
      start_fill(64'h0000_0000_1000_0047);
      wait_done(1, "clean");
      check("clean_latency", done_cyc - accept_cyc, 33);
      check("clean_first_ar", first_ar, 64'h0000_0000_1000_0040);
      check("clean_last_ar", last_ar, 64'h0000_0000_1000_007C);
      check("clean_beats", dv_cnt, 16);
      check("clean_last_idx", last_idx, 15);
      check("clean_error", last_done_err, 0);
      repeat (3) step();

      // Backpressure on both channels
      ar_delay = 3; r_delay = 5;
      clear_stats();
      start_fill(64'h0000_0000_2000_0100);
      wait_done(2, "bp");
      check("bp_beats", dv_cnt, 16);
      check("bp_ars", ar_cnt, 16);
      check("bp_error", last_done_err, 0);
      repeat (3) step();

      // SLVERR on word 5 aborts the fill
      ar_delay = 1; r_delay = 0; err_word = 5;
      clear_stats();
      start_fill(64'h0000_0000_0000_3FC0);
      wait_done(3, "err");
      check("err_beats", dv_cnt, 6);
      check("err_ars", ar_cnt, 6);
      check("err_last_idx", last_idx, 5);
      check("err_flag", last_done_err, 1);
      repeat (6) step();
      check("err_no_more_ar", ar_cnt, 6);
      err_word = -1;

      // Spurious R_VALID during ADDR and a second start mid-fill
      ar_delay = 2; spurious_r = 1'b1;
      clear_stats();
      start_fill(64'hFFFF_FFFF_FFFF_FFC5);
      repeat (10) step();
      start_fill(64'h0000_0000_5555_0000);
      check("spur_busy", o_busy, 1);
      wait_done(4, "spur");
      check("spur_beats", dv_cnt, 16);
      check("spur_first_ar", first_ar, 64'hFFFF_FFFF_FFFF_FFC0);
      check("spur_error", last_done_err, 0);
      spurious_r = 1'b0; ar_delay = 0;
      repeat (3) step();

      // Reset while word 7 is in DATA
      clear_stats();
      start_fill(64'h0000_0000_ABCD_1234);
      n = 0;
      while (!(o_data_valid && o_word_idx == 4'd6) && n < 200) begin step(); n++; end
      check("rst_reach_word6", n < 200, 1);
      step();
      check("rst_in_data", axi_bus.R_READY, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_state", dbg_state, 0);
      check("midrst_busy", o_busy, 0);
      check("midrst_idx", o_word_idx, 0);
      check("midrst_data", o_data, 0);
      check("midrst_ar_addr", axi_bus.AR_ADDR, 0);
      repeat (4) step();
      check("midrst_no_done", done_cnt, 4);
      clear_stats();
      start_fill(64'h0000_0000_0000_0080);
      wait_done(5, "refill");
      check("refill_beats", dv_cnt, 16);
      check("refill_first_idx", first_idx, 0);
      check("refill_first_ar", first_ar, 64'h0000_0000_0000_0080);
      repeat (3) step();

      // Back-to-back fills with start held high
      clear_stats();
      i_start_read = 1'b1;
      i_addr       = 64'h0000_0000_1111_2200;
      step();
      i_addr = 64'h0000_0000_3333_4447;
      wait_done(6, "b2b1");
      d1 = done_cyc;
      clear_stats();
      n = 0;
      while (!o_busy && n < 20) begin step(); n++; end
      i_start_read = 1'b0;
      wait_done(7, "b2b2");
      check("b2b_gap", accept_cyc - d1, 1);
      check("b2b_first_ar", first_ar, 64'h0000_0000_3333_4440);
      check("b2b_beats", dv_cnt, 16);
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
